// File: rtl/contour_tracer.sv
// Finds the first edge pixel by raster scan, then follows its 8-connected boundary
// (Moore-neighbour tracing) and writes a bin label for every traced pixel.
module contour_tracer #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int ADDR_W  = 19,
  parameter int EDGE_W  = 3,
  parameter int BIN_W   = 3,
  parameter int RD_LAT  = 2,
  parameter int LEN_W   = 12,
  parameter int MAX_LEN = 4095
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [11:0]       pixels_per_bin,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [EDGE_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BIN_W-1:0]  wr_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic [LEN_W-1:0]  contour_len
);

  localparam int XW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int WCW = $clog2(RD_LAT + 1);

  localparam logic [XW-1:0]     X_MAX   = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_MAX   = YW'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ROW     = ADDR_W'(WIDTH);
  localparam logic [WCW-1:0]    W_END   = WCW'(RD_LAT);
  localparam logic [LEN_W-1:0]  LEN_END = LEN_W'(MAX_LEN);
  localparam logic [BIN_W-1:0]  LBL_MAX = {BIN_W{1'b1}};

  localparam logic [1:0] ST_CLOSED = 2'b00;
  localparam logic [1:0] ST_OPEN   = 2'b01;
  localparam logic [1:0] ST_LIMIT  = 2'b10;
  localparam logic [1:0] ST_EMPTY  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_WRITE, S_PROBE, S_FINISH} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [XW-1:0]     cur_x_q, cur_x_d;
  logic [YW-1:0]     cur_y_q, cur_y_d;
  logic [ADDR_W-1:0] start_addr_q, start_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [XW-1:0]     nx_q, nx_d;
  logic [YW-1:0]     ny_q, ny_d;
  logic [2:0]        dir_q, dir_d;
  logic [2:0]        d_start_q, d_start_d;
  logic [2:0]        pcnt_q, pcnt_d;
  logic              pend_q, pend_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [11:0]       ppb_q, ppb_d;
  logic [11:0]       seg_q, seg_d;
  logic [BIN_W-1:0]  label_q, label_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [1:0]        status_q, status_d;

  // Neighbour of the current pixel in the direction about to be probed.
  logic [2:0]        enter_dir;
  logic              step_r, step_l, step_d, step_u, nb_oob;
  logic [ADDR_W-1:0] nb_addr;
  logic [XW-1:0]     nb_x;
  logic [YW-1:0]     nb_y;

  always_comb begin
    enter_dir = (state_q == S_WRITE) ? d_start_q : dir_q + 3'd1;
    step_r = 1'b0;
    step_l = 1'b0;
    step_d = 1'b0;
    step_u = 1'b0;
    case (enter_dir)
      3'd0: step_r = 1'b1;
      3'd1: begin step_r = 1'b1; step_d = 1'b1; end
      3'd2: step_d = 1'b1;
      3'd3: begin step_l = 1'b1; step_d = 1'b1; end
      3'd4: step_l = 1'b1;
      3'd5: begin step_l = 1'b1; step_u = 1'b1; end
      3'd6: step_u = 1'b1;
      default: begin step_r = 1'b1; step_u = 1'b1; end
    endcase
    nb_oob = (step_r && cur_x_q == X_MAX) || (step_l && cur_x_q == '0) ||
             (step_d && cur_y_q == Y_MAX) || (step_u && cur_y_q == '0);
    nb_addr = cur_addr_q;
    nb_x    = cur_x_q;
    nb_y    = cur_y_q;
    if (step_r) begin nb_addr = nb_addr + ADDR_W'(1); nb_x = nb_x + XW'(1); end
    if (step_l) begin nb_addr = nb_addr - ADDR_W'(1); nb_x = nb_x - XW'(1); end
    if (step_d) begin nb_addr = nb_addr + ROW;        nb_y = nb_y + YW'(1); end
    if (step_u) begin nb_addr = nb_addr - ROW;        nb_y = nb_y - YW'(1); end
  end

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    start_addr_d = start_addr_q;
    rd_addr_d    = rd_addr_q;
    nx_d         = nx_q;
    ny_d         = ny_q;
    dir_d        = dir_q;
    d_start_d    = d_start_q;
    pcnt_d       = pcnt_q;
    pend_d       = pend_q;
    wcnt_d       = wcnt_q;
    ppb_d        = ppb_q;
    seg_d        = seg_q;
    label_d      = label_q;
    len_d        = len_q;
    status_d     = status_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ppb_d      = (pixels_per_bin == 12'd0) ? 12'd1 : pixels_per_bin;
          cur_addr_d = '0;
          cur_x_d    = '0;
          cur_y_d    = '0;
          rd_addr_d  = '0;
          wcnt_d     = '0;
          label_d    = BIN_W'(1);
          seg_d      = '0;
          len_d      = '0;
          state_d    = S_SCAN;
        end
      end

      S_SCAN: begin
        if (wcnt_q != W_END) begin
          wcnt_d = wcnt_q + WCW'(1);
        end else if (rd_data != '0) begin
          start_addr_d = cur_addr_q;
          d_start_d    = 3'd0;
          state_d      = S_WRITE;
        end else if (cur_addr_q == LAST) begin
          status_d = ST_EMPTY;
          len_d    = '0;
          state_d  = S_FINISH;
        end else begin
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          rd_addr_d  = cur_addr_q + ADDR_W'(1);
          wcnt_d     = '0;
          if (cur_x_q == X_MAX) begin
            cur_x_d = '0;
            cur_y_d = cur_y_q + YW'(1);
          end else begin
            cur_x_d = cur_x_q + XW'(1);
          end
        end
      end

      S_WRITE: begin
        len_d = len_q + LEN_W'(1);
        if (seg_q + 12'd1 == ppb_q) begin
          seg_d = '0;
          if (label_q != LBL_MAX) label_d = label_q + BIN_W'(1);
        end else begin
          seg_d = seg_q + 12'd1;
        end
        if (len_d == LEN_END) begin
          status_d = ST_LIMIT;
          state_d  = S_FINISH;
        end else begin
          // Issue the first probe now so each in-bounds probe costs RD_LAT+1 cycles.
          state_d = S_PROBE;
          pcnt_d  = '0;
          dir_d   = enter_dir;
          pend_d  = !nb_oob;
          wcnt_d  = '0;
          if (!nb_oob) begin
            rd_addr_d = nb_addr;
            nx_d      = nb_x;
            ny_d      = nb_y;
          end
        end
      end

      S_PROBE: begin
        if (pend_q && wcnt_q != W_END) begin
          wcnt_d = wcnt_q + WCW'(1);
        end else if (pend_q && rd_data != '0) begin
          if (rd_addr_q == start_addr_q) begin
            status_d = ST_CLOSED;
            state_d  = S_FINISH;
          end else begin
            cur_addr_d = rd_addr_q;
            cur_x_d    = nx_q;
            cur_y_d    = ny_q;
            // Restart the sweep just behind the backtrack pixel.
            d_start_d  = dir_q[0] ? dir_q + 3'd6 : dir_q + 3'd7;
            state_d    = S_WRITE;
          end
        end else if (pcnt_q == 3'd7) begin
          status_d = ST_OPEN;
          state_d  = S_FINISH;
        end else begin
          pcnt_d = pcnt_q + 3'd1;
          dir_d  = enter_dir;
          pend_d = !nb_oob;
          wcnt_d = '0;
          if (!nb_oob) begin
            rd_addr_d = nb_addr;
            nx_d      = nb_x;
            ny_d      = nb_y;
          end
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      start_addr_q <= '0;
      rd_addr_q    <= '0;
      nx_q         <= '0;
      ny_q         <= '0;
      dir_q        <= '0;
      d_start_q    <= '0;
      pcnt_q       <= '0;
      pend_q       <= 1'b0;
      wcnt_q       <= '0;
      ppb_q        <= 12'd1;
      seg_q        <= '0;
      label_q      <= '0;
      len_q        <= '0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      start_addr_q <= start_addr_d;
      rd_addr_q    <= rd_addr_d;
      nx_q         <= nx_d;
      ny_q         <= ny_d;
      dir_q        <= dir_d;
      d_start_q    <= d_start_d;
      pcnt_q       <= pcnt_d;
      pend_q       <= pend_d;
      wcnt_q       <= wcnt_d;
      ppb_q        <= ppb_d;
      seg_q        <= seg_d;
      label_q      <= label_d;
      len_q        <= len_d;
      status_q     <= status_d;
    end
  end

  assign rd_addr     = rd_addr_q;
  assign wr_en       = (state_q == S_WRITE);
  assign wr_addr     = cur_addr_q;
  assign wr_data     = label_q;
  assign busy        = (state_q == S_SCAN) || (state_q == S_WRITE) || (state_q == S_PROBE);
  assign done        = (state_q == S_FINISH);
  assign status      = status_q;
  assign contour_len = len_q;

endmodule

// File: tb/tb_contour_tracer.sv
// Directed bench: four tracer instances (default, 2-bit labels, MAX_LEN=4, tiny
// empty image) share one edge-map model, each behind its own read-latency pipe.
module tb_contour_tracer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] ppb = 12'd0;
  always #5 clk = ~clk;

  logic [2:0] mem [0:10239];
  int n_assert = 0;
  int n_fail   = 0;
  int b2b      = 0;
  logic prev_wr = 1'b0;

  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0, start_d = 1'b0;
  logic [18:0] rd_addr_a, rd_addr_b, rd_addr_c, rd_addr_d;
  logic [2:0]  rd_data_a, rd_data_b, rd_data_c, rd_data_d;
  logic        wr_en_a, wr_en_b, wr_en_c, wr_en_d;
  logic [18:0] wr_addr_a, wr_addr_b, wr_addr_c, wr_addr_d;
  logic [2:0]  wr_data_a, wr_data_c, wr_data_d;
  logic [1:0]  wr_data_b;
  logic        busy_a, busy_b, busy_c, busy_d;
  logic        done_a, done_b, done_c, done_d;
  logic [1:0]  status_a, status_b, status_c, status_d;
  logic [11:0] len_a, len_b, len_c, len_d;

  contour_tracer #(.HEIGHT(16)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .pixels_per_bin(ppb),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .busy(busy_a), .done(done_a), .status(status_a), .contour_len(len_a));

  contour_tracer #(.HEIGHT(16), .BIN_W(2), .RD_LAT(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .pixels_per_bin(ppb),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .busy(busy_b), .done(done_b), .status(status_b), .contour_len(len_b));

  contour_tracer #(.HEIGHT(16), .RD_LAT(1), .MAX_LEN(4)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .pixels_per_bin(ppb),
    .rd_addr(rd_addr_c), .rd_data(rd_data_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
    .wr_data(wr_data_c), .busy(busy_c), .done(done_c), .status(status_c), .contour_len(len_c));

  contour_tracer #(.HEIGHT(2)) u_d (
    .clk(clk), .rst(rst), .start(start_d), .pixels_per_bin(ppb),
    .rd_addr(rd_addr_d), .rd_data(rd_data_d), .wr_en(wr_en_d), .wr_addr(wr_addr_d),
    .wr_data(wr_data_d), .busy(busy_d), .done(done_d), .status(status_d), .contour_len(len_d));

  function automatic logic [2:0] rdm(input logic [18:0] a);
    if (a < 19'd10240) return mem[a[13:0]];
    return 3'd0;
  endfunction

  logic [2:0] a_p1 = '0, a_p2 = '0, d_p1 = '0, d_p2 = '0, b_p1 = '0, c_p1 = '0;
  always @(posedge clk) begin
    a_p1 <= rdm(rd_addr_a);
    a_p2 <= a_p1;
    d_p1 <= rdm(rd_addr_d);
    d_p2 <= d_p1;
    b_p1 <= rdm(rd_addr_b);
    c_p1 <= rdm(rd_addr_c);
  end
  assign rd_data_a = a_p2;
  assign rd_data_b = b_p1;
  assign rd_data_c = c_p1;
  assign rd_data_d = d_p2;

  int wa_q[$];
  int wd_q[$];
  int ra_q[$];
  logic [18:0] last_rd_a = '0;
  always @(negedge clk) begin
    logic any;
    if (wr_en_a)      begin wa_q.push_back(int'(wr_addr_a)); wd_q.push_back(int'(wr_data_a)); end
    else if (wr_en_b) begin wa_q.push_back(int'(wr_addr_b)); wd_q.push_back(int'(wr_data_b)); end
    else if (wr_en_c) begin wa_q.push_back(int'(wr_addr_c)); wd_q.push_back(int'(wr_data_c)); end
    else if (wr_en_d) begin wa_q.push_back(int'(wr_addr_d)); wd_q.push_back(int'(wr_data_d)); end
    any = wr_en_a | wr_en_b | wr_en_c | wr_en_d;
    if (any && prev_wr) b2b++;
    prev_wr = any;
    if (busy_a && rd_addr_a != last_rd_a) ra_q.push_back(int'(rd_addr_a));
    last_rd_a = rd_addr_a;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic logic done_of(input int id);
    case (id)
      0: return done_a;
      1: return done_b;
      2: return done_c;
      default: return done_d;
    endcase
  endfunction

  function automatic logic busy_of(input int id);
    case (id)
      0: return busy_a;
      1: return busy_b;
      2: return busy_c;
      default: return busy_d;
    endcase
  endfunction

  task automatic set_start(input int id, input logic v);
    case (id)
      0: start_a = v;
      1: start_b = v;
      2: start_c = v;
      default: start_d = v;
    endcase
  endtask

  // Pulses start, then counts cycles (1 = first busy cycle) until done.
  task automatic run(input string tag, input int id, input int budget, output int cyc);
    wa_q.delete();
    wd_q.delete();
    ra_q.delete();
    set_start(id, 1'b1);
    tick();
    set_start(id, 1'b0);
    cyc = 1;
    check({tag, "_busy_rise"}, 32'(busy_of(id)), 32'd1);
    while (!done_of(id) && cyc < budget) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, 32'(done_of(id)), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy_of(id)), 32'd0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 10240; i++) mem[i] = 3'd0;
  endtask

  task automatic set_px(input int x, input int y, input logic [2:0] v);
    mem[y * 640 + x] = v;
  endtask

  task automatic put_ring();
    for (int i = 10; i <= 12; i++) begin
      set_px(i, 10, 3'd1);
      set_px(i, 12, 3'd6);
    end
    set_px(10, 11, 3'd2);
    set_px(12, 11, 3'd7);
  endtask

  initial begin
    int cyc;
    int ring_a[8] = '{6410, 6411, 6412, 7052, 7692, 7691, 7690, 7050};
    int ring_l[8] = '{1, 1, 1, 2, 2, 2, 3, 3};
    int line_a[8] = '{3220, 3221, 3222, 3223, 3224, 3223, 3222, 3221};
    int line_l[8] = '{1, 2, 3, 3, 3, 3, 3, 3};
    int seen;
    logic saw_done;

    clear_mem();
    tick();
    check("rst_busy",   32'(busy_a),    32'd0);
    check("rst_done",   32'(done_a),    32'd0);
    check("rst_wr_en",  32'(wr_en_a),   32'd0);
    check("rst_status", 32'(status_a),  32'd0);
    check("rst_len",    32'(len_a),     32'd0);
    check("rst_rdaddr", 32'(rd_addr_a), 32'd0);
    rst = 1'b0;
    tick();

    // Closed 3x3 ring
    put_ring();
    ppb = 12'd3;
    run("ring", 0, 25000, cyc);
    check("ring_nwr", wa_q.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < wa_q.size()) begin
        check($sformatf("ring_addr%0d", i), wa_q[i], ring_a[i]);
        check($sformatf("ring_lbl%0d", i), wd_q[i], ring_l[i]);
      end
    check("ring_status", 32'(status_a), 32'd0);
    check("ring_len", 32'(len_a), 32'd8);
    tick();
    check("ring_status_hold", 32'(status_a), 32'd0);
    check("ring_len_hold", 32'(len_a), 32'd8);

    // Isolated pixel in the corner: only R, DR, D may be read
    clear_mem();
    set_px(0, 0, 3'd4);
    ppb = 12'd0;
    run("corner", 0, 200, cyc);
    check("corner_nwr", wa_q.size(), 32'd1);
    if (wa_q.size() > 0) begin
      check("corner_addr", wa_q[0], 32'd0);
      check("corner_lbl", wd_q[0], 32'd1);
    end
    check("corner_nrd", ra_q.size(), 32'd4);
    if (ra_q.size() == 4) begin
      check("corner_rd_r",  ra_q[1], 32'd1);
      check("corner_rd_dr", ra_q[2], 32'd641);
      check("corner_rd_d",  ra_q[3], 32'd640);
    end
    check("corner_status", 32'(status_a), 32'd1);
    check("corner_len", 32'(len_a), 32'd1);

    // Open line traced out and back, saturating 2-bit labels
    clear_mem();
    for (int x = 20; x <= 24; x++) set_px(x, 5, 3'd3);
    ppb = 12'd1;
    run("line", 1, 10000, cyc);
    check("line_nwr", wa_q.size(), 32'd8);
    for (int i = 0; i < 8; i++)
      if (i < wa_q.size()) begin
        check($sformatf("line_addr%0d", i), wa_q[i], line_a[i]);
        check($sformatf("line_lbl%0d", i), wd_q[i], line_l[i]);
      end
    check("line_status", 32'(status_b), 32'd0);
    check("line_len", 32'(len_b), 32'd8);

    // Empty 640x2 map: 1280 pixels * 3 cycles
    clear_mem();
    run("empty", 3, 5000, cyc);
    check("empty_nwr", wa_q.size(), 32'd0);
    check("empty_status", 32'(status_d), 32'd3);
    check("empty_len", 32'(len_d), 32'd0);
    check("empty_cyc_lo", 32'(cyc >= 3840), 32'd1);
    check("empty_cyc_hi", 32'(cyc <= 3845), 32'd1);

    // Length limit at 4
    put_ring();
    ppb = 12'd3;
    run("limit", 2, 16000, cyc);
    check("limit_nwr", wa_q.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < wa_q.size()) begin
        check($sformatf("limit_addr%0d", i), wa_q[i], ring_a[i]);
        check($sformatf("limit_lbl%0d", i), wd_q[i], ring_l[i]);
      end
    check("limit_status", 32'(status_c), 32'd2);
    check("limit_len", 32'(len_c), 32'd4);

    // Same trace, reset after the second write
    tick();
    wa_q.delete();
    wd_q.delete();
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    seen = 0;
    while (wa_q.size() < 2 && seen < 16000) begin
      tick();
      seen++;
    end
    check("rstmid_reached", wa_q.size(), 32'd2);
    rst = 1'b1;
    #1;
    check("rstmid_busy", 32'(busy_c), 32'd0);
    check("rstmid_done", 32'(done_c), 32'd0);
    check("rstmid_status", 32'(status_c), 32'd0);
    check("rstmid_len", 32'(len_c), 32'd0);
    check("rstmid_wr_en", 32'(wr_en_c), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (done_c || busy_c) saw_done = 1'b1;
    end
    check("rstmid_quiet", 32'(saw_done), 32'd0);
    check("rstmid_nwr", wa_q.size(), 32'd2);
    check("no_b2b_wr", 32'(b2b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
